// File: rtl/line_mem_responder_pkg.sv
// Shared types and width helpers for the line memory responder.
// Width helpers take the module parameters because a package cannot see them.
package line_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int DEF_LINE_SIZE = 16;
  localparam int DEF_NUM_LINES = 1024;
  localparam int DEF_LATENCY   = 50;
  localparam int ADDR_BITS     = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int line_bits(input int line_size);
    return line_size * 8;
  endfunction

  function automatic int idx_bits(input int num_lines);
    return clog2(num_lines);
  endfunction

  function automatic int cnt_bits(input int latency);
    return clog2(latency + 1);
  endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Request/response bus between the cache memory-side port and the line memory.
// master = the cache side issuing requests, slave = the memory answering them.
interface line_mem_responder_if
  import line_mem_responder_pkg::*;
#(
  parameter int LINE_SIZE = DEF_LINE_SIZE
);
  logic                         is_input_valid;
  logic [ADDR_BITS-1:0]         addr;
  logic                         mem_read;
  logic                         mem_write;
  logic [LINE_SIZE*8-1:0]       din;
  logic                         is_output_valid;
  logic [LINE_SIZE*8-1:0]       dout;
  logic                         mem_ready;

  modport master (
    output is_input_valid, addr, mem_read, mem_write, din,
    input  is_output_valid, dout, mem_ready
  );

  modport slave (
    input  is_input_valid, addr, mem_read, mem_write, din,
    output is_output_valid, dout, mem_ready
  );
endinterface

// File: rtl/line_mem_responder_array.sv
// Single-port line storage: synchronous write, combinational read of the
// selected line, every line cleared while reset is held.
module line_mem_array #(
  parameter int LINE_BITS = 128,
  parameter int NUM_LINES = 1024,
  parameter int IDX_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_we,
  input  logic [IDX_BITS-1:0]  i_idx,
  input  logic [LINE_BITS-1:0] i_wdata,
  output logic [LINE_BITS-1:0] o_rdata
);

  logic [LINE_BITS-1:0] r_mem [NUM_LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory: accepts one read or write at a time, holds it for
// LATENCY cycles, then commits the write or returns the line with a 1-cycle pulse.
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int LINE_SIZE = DEF_LINE_SIZE,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  line_mem_responder_if.slave  bus
);

  localparam int LINE_BITS = line_bits(LINE_SIZE);
  localparam int IDX_BITS  = idx_bits(NUM_LINES);
  localparam int CNT_BITS  = cnt_bits(LATENCY);
  localparam logic [CNT_BITS-1:0] CNT_START = CNT_BITS'(LATENCY - 1);

  state_t                r_state;
  op_t                   r_op;
  logic [CNT_BITS-1:0]   r_cnt;
  logic [IDX_BITS-1:0]   r_idx;
  logic [LINE_BITS-1:0]  r_din;
  logic [LINE_BITS-1:0]  r_dout;
  logic                  r_out_valid;
  logic                  r_ready;

  logic                  w_legal;
  logic                  w_can_accept;
  logic                  w_accept;
  logic                  w_finish;
  logic                  w_we;
  logic [LINE_BITS-1:0]  w_rdata;

  // Exactly one of read/write must be set; anything else is silently dropped.
  assign w_legal      = bus.is_input_valid && (bus.mem_read ^ bus.mem_write);
  assign w_can_accept = (r_state == IDLE) || (r_state == DONE);
  assign w_accept     = w_can_accept && w_legal;
  assign w_finish     = (r_state == BUSY) && (r_cnt == '0);
  assign w_we         = w_finish && (r_op == OP_WRITE);

  line_mem_array #(
    .LINE_BITS (LINE_BITS),
    .NUM_LINES (NUM_LINES),
    .IDX_BITS  (IDX_BITS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (r_din),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= OP_READ;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_din       <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_idx   <= bus.addr[IDX_BITS-1:0];
            r_op    <= bus.mem_write ? OP_WRITE : OP_READ;
            r_din   <= bus.din;
            r_cnt   <= CNT_START;
            r_state <= BUSY;
            r_ready <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            if (r_op == OP_READ) begin
              r_dout      <= w_rdata;
              r_out_valid <= 1'b1;
            end
            r_state <= DONE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.dout            = r_dout;
  assign bus.is_output_valid = r_out_valid;
  assign bus.mem_ready       = r_ready;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder with a small array and short latency.
module tb_line_mem_responder;

  localparam int LINE_SIZE = 16;
  localparam int NUM_LINES = 16;
  localparam int LATENCY   = 4;
  localparam int LB        = LINE_SIZE * 8;
  localparam int TIMEOUT   = 20;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  line_mem_responder_if #(.LINE_SIZE(LINE_SIZE)) bus ();

  line_mem_responder #(
    .LINE_SIZE (LINE_SIZE),
    .NUM_LINES (NUM_LINES),
    .LATENCY   (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_bus();
    bus.is_input_valid = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
  endtask

  // Present a request at a negedge; returns at the following negedge.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [LB-1:0] d);
    bus.is_input_valid = 1'b1;
    bus.mem_read       = rd;
    bus.mem_write      = wr;
    bus.addr           = a;
    bus.din            = d;
    @(negedge clk);
    idle_bus();
  endtask

  // Wait for mem_ready to return, optionally scrambling the bus while busy.
  task automatic wait_done(input bit noise, output int cycles, output bit saw_ov,
                           output logic [LB-1:0] data, output bit timed_out);
    cycles    = 0;
    saw_ov    = 1'b0;
    data      = '0;
    timed_out = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.is_output_valid === 1'b1) begin
        saw_ov = 1'b1;
        data   = bus.dout;
      end
      if (bus.mem_ready === 1'b1) begin
        idle_bus();
        timed_out = 1'b0;
        break;
      end
      if (noise) begin
        bus.is_input_valid = 1'b1;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b1;
        bus.addr           = 32'd11 + 32'(i);
        bus.din            = {4{32'hA5A5_0000 + 32'(i)}};
      end
    end
  endtask

  task automatic do_read(input string nm, input logic [31:0] a, input logic [LB-1:0] exp_d);
    int cyc; bit ov; logic [LB-1:0] d; bit to;
    issue(1'b1, 1'b0, a, '0);
    wait_done(1'b0, cyc, ov, d, to);
    n_checks++;
    if (to || !ov || d !== exp_d) begin
      n_fail++;
      $display("FAIL %s: timeout=%0b valid=%0b dout=%h expected %h", nm, to, ov, d, exp_d);
    end
  endtask

  task automatic do_write(input string nm, input logic [31:0] a, input logic [LB-1:0] d);
    int cyc; bit ov; logic [LB-1:0] rd; bit to;
    issue(1'b0, 1'b1, a, d);
    wait_done(1'b0, cyc, ov, rd, to);
    n_checks++;
    if (to || ov) begin
      n_fail++;
      $display("FAIL %s: timeout=%0b output_valid_pulse=%0b expected 0/0", nm, to, ov);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_bus();
    bus.addr = '0;
    bus.din  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.mem_ready);
    end
    n_checks++;
    if (bus.is_output_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.is_output_valid);
    end
    n_checks++;
    if (bus.dout !== '0) begin
      n_fail++; $display("FAIL reset_dout: got %h expected 0", bus.dout);
    end
  endtask

  task automatic test_read_latency();
    int cyc; bit ov; logic [LB-1:0] d; bit to;
    issue(1'b1, 1'b0, 32'd5, '0);
    n_checks++;
    if (bus.mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL rd_busy_ready: got %b expected 0", bus.mem_ready);
    end
    wait_done(1'b0, cyc, ov, d, to);
    n_checks++;
    if (to || cyc != LATENCY) begin
      n_fail++; $display("FAIL rd_latency: got %0d cycles (timeout=%0b) expected %0d", cyc, to, LATENCY);
    end
    n_checks++;
    if (!ov || d !== '0) begin
      n_fail++; $display("FAIL rd_data5: valid=%0b dout=%h expected 1/0", ov, d);
    end
    @(negedge clk);
    n_checks++;
    if (bus.is_output_valid !== 1'b0 || bus.mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_pulse_width: valid=%b ready=%b expected 0/1", bus.is_output_valid, bus.mem_ready);
    end
  endtask

  task automatic test_write_read();
    do_write("wr3_no_pulse", 32'd3, 128'hDEADBEEF_00000001_00000002_00000003);
    do_read("rd3_data", 32'd3, 128'hDEADBEEF_00000001_00000002_00000003);
  endtask

  task automatic test_back_to_back();
    int cyc; bit ov; logic [LB-1:0] d; bit to;
    issue(1'b0, 1'b1, 32'd4, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    wait_done(1'b0, cyc, ov, d, to);
    // Now in the DONE cycle of the write: present the read immediately.
    issue(1'b1, 1'b0, 32'd4, '0);
    n_checks++;
    if (bus.mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: ready=%b expected 0", bus.mem_ready);
    end
    wait_done(1'b0, cyc, ov, d, to);
    n_checks++;
    if (to || cyc != LATENCY || !ov || d !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin
      n_fail++;
      $display("FAIL b2b_read: cycles=%0d valid=%0b dout=%h expected %0d/1/0123456789abcdeffedcba9876543210",
               cyc, ov, d, LATENCY);
    end
  endtask

  task automatic test_wrap_illegal();
    do_write("wrap_wr", NUM_LINES + 7, 128'h7777_0000_1111_2222_3333_4444_5555_6666);
    do_read("wrap_rd7", 32'd7, 128'h7777_0000_1111_2222_3333_4444_5555_6666);
    @(negedge clk);
    issue(1'b1, 1'b1, 32'd7, 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0);
    n_checks++;
    if (bus.mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL illegal_both: ready=%b expected 1", bus.mem_ready);
    end
    issue(1'b0, 1'b0, 32'd7, 128'hBAD1_BAD1_BAD1_BAD1_BAD1_BAD1_BAD1_BAD1);
    n_checks++;
    if (bus.mem_ready !== 1'b1 || bus.is_output_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_none: ready=%b valid=%b expected 1/0", bus.mem_ready, bus.is_output_valid);
    end
    do_read("illegal_no_write", 32'd7, 128'h7777_0000_1111_2222_3333_4444_5555_6666);
  endtask

  task automatic test_reset_mid_write();
    issue(1'b0, 1'b1, 32'd9, 128'h9999_9999_9999_9999_9999_9999_9999_9999);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (bus.mem_ready !== 1'b1 || bus.is_output_valid !== 1'b0 || bus.dout !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: ready=%b valid=%b dout=%h expected 1/0/0",
               bus.mem_ready, bus.is_output_valid, bus.dout);
    end
    repeat (LATENCY + 2) @(negedge clk);
    do_read("midrst_rd9", 32'd9, '0);
    do_read("midrst_rd3_cleared", 32'd3, '0);
  endtask

  task automatic test_bus_noise();
    int cyc; bit ov; logic [LB-1:0] d; bit to;
    issue(1'b0, 1'b1, 32'd10, 128'hC0DE_CAFE_1234_5678_0BAD_F00D_AAAA_5555);
    wait_done(1'b1, cyc, ov, d, to);
    n_checks++;
    if (to || ov) begin
      n_fail++; $display("FAIL noise_write: timeout=%0b valid=%0b expected 0/0", to, ov);
    end
    @(negedge clk);
    do_read("noise_rd10", 32'd10, 128'hC0DE_CAFE_1234_5678_0BAD_F00D_AAAA_5555);
    do_read("noise_rd11_untouched", 32'd11, '0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_read_latency();
    test_write_read();
    test_back_to_back();
    test_wrap_illegal();
    test_reset_mid_write();
    test_bus_noise();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
